text_buffer_writer: RTL and testbench

- Character-buffer writer for the on-screen text overlay.
- Accepts a byte stream of ASCII characters (from game logic or UART) over a valid/ready handshake.
- Interprets basic control codes, places printable characters at a hardware cursor, and stores them in an internal 16x16 character RAM.
- Exposes a synchronous read port addressed by the overlay drawer's `char_xy`; the drawer consumes `rd_char` as the font-ROM character code.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/text_ram.sv | 39 +++
 rtl/text_buffer_writer.sv | 144 ++++++++++++++
 tb/tb_text_buffer_writer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA text overlay path.
package vga_pkg;

    // Default text grid geometry (16 columns x 16 rows).
    localparam int TEXT_COL_BITS = 4;
    localparam int TEXT_ROW_BITS = 4;
    localparam int TEXT_COLS     = 2 ** TEXT_COL_BITS;
    localparam int TEXT_ROWS     = 2 ** TEXT_ROW_BITS;

    // Fill value used when the screen is swept clean (ASCII space).
    localparam logic [7:0] TEXT_CLEAR_CHAR = 8'h20;

    // Control codes understood by the text writer.
    localparam logic [7:0] ASCII_BS = 8'h08;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_FF = 8'h0C;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    // Inclusive bounds of the printable ASCII range.
    localparam logic [7:0] ASCII_PRINT_MIN = 8'h20;
    localparam logic [7:0] ASCII_PRINT_MAX = 8'h7E;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } text_wr_state_t;

endpackage

// File: rtl/text_ram.sv
// Simple dual-port character RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old data.
module text_ram #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [DATA_BITS-1:0] rd_data_reg;

    // Write port; the array itself is never reset, a clear sweep initialises it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; only the output register is cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/text_buffer_writer.sv
// Character-buffer writer: takes an ASCII byte stream, interprets control
// codes, places printable characters at a hardware cursor and stores them in
// a character RAM that the overlay drawer reads back.
module text_buffer_writer
    import vga_pkg::*;
#(
    parameter int         COL_BITS   = TEXT_COL_BITS,
    parameter int         ROW_BITS   = TEXT_ROW_BITS,
    parameter logic [7:0] CLEAR_CHAR = TEXT_CLEAR_CHAR
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   ch_data,
    input  logic                         ch_valid,
    output logic                         ch_ready,
    input  logic                         clear_req,
    input  logic [ROW_BITS+COL_BITS-1:0] rd_xy,
    output logic [7:0]                   rd_char,
    output logic [ROW_BITS+COL_BITS-1:0] cursor_xy,
    output logic                         busy
);

    localparam int ADDR_BITS = ROW_BITS + COL_BITS;

    text_wr_state_t        state_reg;
    logic [ADDR_BITS-1:0]  clr_addr_reg;
    logic [ROW_BITS-1:0]   row_reg;
    logic [COL_BITS-1:0]   col_reg;
    logic                  busy_reg;

    logic                  transfer;
    logic                  is_print;
    logic [COL_BITS-1:0]   col_prev;
    logic                  wr_en;
    logic [ADDR_BITS-1:0]  wr_addr;
    logic [7:0]            wr_data;

    // A clear request always wins over a byte offered in the same cycle.
    assign ch_ready  = (state_reg == IDLE) && !clear_req;
    assign transfer  = ch_valid && ch_ready;
    assign is_print  = (ch_data >= ASCII_PRINT_MIN) && (ch_data <= ASCII_PRINT_MAX);
    assign col_prev  = col_reg - 1'b1;
    assign cursor_xy = {row_reg, col_reg};
    assign busy      = busy_reg;

    // Write-port mux: the clear sweep owns the port, otherwise the cursor does.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_addr_reg;
        wr_data = CLEAR_CHAR;
        if (state_reg == CLEAR) begin
            wr_en = 1'b1;
        end else if (transfer) begin
            if (is_print) begin
                wr_en   = 1'b1;
                wr_addr = {row_reg, col_reg};
                wr_data = ch_data;
            end else if ((ch_data == ASCII_BS) && (col_reg != '0)) begin
                wr_en   = 1'b1;
                wr_addr = {row_reg, col_prev};
                wr_data = CLEAR_CHAR;
            end
        end
    end

    // FSM, sweep counter and cursor; row/col wrap through natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= CLEAR;
            clr_addr_reg <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
            busy_reg     <= 1'b1;
        end else begin
            case (state_reg)
                CLEAR: begin
                    // Counter rolls over to zero on the last address.
                    clr_addr_reg <= clr_addr_reg + 1'b1;
                    if (clr_addr_reg == '1) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (clear_req) begin
                        state_reg    <= CLEAR;
                        busy_reg     <= 1'b1;
                        clr_addr_reg <= '0;
                        row_reg      <= '0;
                        col_reg      <= '0;
                    end else if (transfer) begin
                        if (is_print) begin
                            col_reg <= col_reg + 1'b1;
                            if (col_reg == '1) begin
                                row_reg <= row_reg + 1'b1;
                            end
                        end else begin
                            case (ch_data)
                                ASCII_LF: begin
                                    col_reg <= '0;
                                    row_reg <= row_reg + 1'b1;
                                end
                                ASCII_CR: begin
                                    col_reg <= '0;
                                end
                                ASCII_BS: begin
                                    if (col_reg != '0) begin
                                        col_reg <= col_prev;
                                    end
                                end
                                ASCII_FF: begin
                                    state_reg    <= CLEAR;
                                    busy_reg     <= 1'b1;
                                    clr_addr_reg <= '0;
                                    row_reg      <= '0;
                                    col_reg      <= '0;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    state_reg <= CLEAR;
                end
            endcase
        end
    end

    text_ram #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (8)
    ) u_text_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_xy),
        .rd_data (rd_char)
    );

endmodule

// File: tb/tb_text_buffer_writer.sv
// Self-checking bench for text_buffer_writer: directed scenarios plus a
// randomized byte stream, all compared against a screen/cursor model.
module tb_text_buffer_writer;

    localparam int SWEEP = 256;

    logic       clk;
    logic       rst;
    logic [7:0] ch_data;
    logic       ch_valid;
    logic       ch_ready;
    logic       clear_req;
    logic [7:0] rd_xy;
    logic [7:0] rd_char;
    logic [7:0] cursor_xy;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: screen contents, which cells are known, cursor as a
    // linear cell index, and remaining cycles of an ongoing clear sweep.
    logic [7:0] mem_m   [SWEEP];
    bit         known_m [SWEEP];
    int         cur_m;
    int         sweep_left_m;

    text_buffer_writer dut (
        .clk       (clk),
        .rst       (rst),
        .ch_data   (ch_data),
        .ch_valid  (ch_valid),
        .ch_ready  (ch_ready),
        .clear_req (clear_req),
        .rd_xy     (rd_xy),
        .rd_char   (rd_char),
        .cursor_xy (cursor_xy),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Effect of one accepted byte on the model screen.
    task automatic model_byte(input logic [7:0] d);
        if (d >= 8'h20 && d <= 8'h7E) begin
            mem_m[cur_m]   = d;
            known_m[cur_m] = 1'b1;
            cur_m = (cur_m + 1) % 256;
        end else if (d == 8'h0A) begin
            cur_m = (((cur_m / 16) + 1) % 16) * 16;
        end else if (d == 8'h0D) begin
            cur_m = (cur_m / 16) * 16;
        end else if (d == 8'h08) begin
            if ((cur_m % 16) > 0) begin
                cur_m = cur_m - 1;
                mem_m[cur_m]   = 8'h20;
                known_m[cur_m] = 1'b1;
            end
        end else if (d == 8'h0C) begin
            cur_m = 0;
            sweep_left_m = SWEEP;
        end
    endtask

    // One clock cycle: drive inputs, check ready mid-cycle, then check
    // registered outputs just after the edge against the updated model.
    task automatic cycle(input logic [7:0] d, input logic v, input logic c,
                         input logic [7:0] a, input logic r);
        logic       exp_ready;
        logic       rd_known;
        logic [7:0] exp_rd;
        logic       took;
        ch_data   = d;
        ch_valid  = v;
        clear_req = c;
        rd_xy     = a;
        rst       = r;
        #4;
        exp_ready = (sweep_left_m == 0) && !c;
        check("ch_ready", ch_ready, exp_ready);
        rd_known = known_m[a];
        exp_rd   = mem_m[a];
        took     = exp_ready && v && !r;
        @(posedge clk);
        #1;
        if (r) begin
            sweep_left_m = SWEEP;
            cur_m = 0;
        end else if (sweep_left_m > 0) begin
            mem_m[SWEEP - sweep_left_m]   = 8'h20;
            known_m[SWEEP - sweep_left_m] = 1'b1;
            sweep_left_m--;
        end else if (c) begin
            cur_m = 0;
            sweep_left_m = SWEEP;
        end else if (v) begin
            model_byte(d);
        end
        if (r) begin
            check("rd_char_rst", rd_char, 8'h00);
        end else if (rd_known) begin
            check("rd_char", rd_char, exp_rd);
        end
        check("cursor_xy", cursor_xy, cur_m[7:0]);
        check("busy", busy, sweep_left_m > 0);
        if (took) begin
            $display("xfer data=%02h cursor=%02h", d, cursor_xy);
        end
    endtask

    task automatic idle(input logic [7:0] a);
        cycle(8'h00, 1'b0, 1'b0, a, 1'b0);
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] a);
        cycle(d, 1'b1, 1'b0, a, 1'b0);
    endtask

    // Count busy cycles starting with the cycle just run; bounded wait.
    task automatic measure_sweep(input string tag);
        int n;
        n = busy ? 1 : 0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            idle(8'($urandom));
            if (busy) n++;
        end
        check(tag, n, SWEEP);
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] d;
        int         sel;

        rst       = 1'b1;
        ch_data   = 8'h00;
        ch_valid  = 1'b0;
        clear_req = 1'b0;
        rd_xy     = 8'h00;
        for (int i = 0; i < SWEEP; i++) begin
            known_m[i] = 1'b0;
            mem_m[i]   = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        cur_m        = 0;
        sweep_left_m = SWEEP;

        // Reset state and the initial sweep.
        cycle(8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        check("rst_busy", busy, 1'b1);
        check("rst_cursor", cursor_xy, 8'h00);
        check("rst_rd_char", rd_char, 8'h00);
        measure_sweep("reset_sweep_len");
        for (int i = 0; i < SWEEP; i++) begin
            idle(8'(i));
            if (i > 0) check("clear_fill", rd_char, 8'h20);
        end
        idle(8'hFF);
        check("clear_fill_last", rd_char, 8'h20);
        check("home_cursor", cursor_xy, 8'h00);

        // Back-to-back "A", "B".
        send(8'h41, 8'h00);
        send(8'h42, 8'h00);
        check("ab_cursor", cursor_xy, 8'h02);
        idle(8'h01);
        check("ab_read_b", rd_char, 8'h42);
        idle(8'h00);
        check("ab_read_a", rd_char, 8'h41);

        // Column wrap from 0x0F to 0x10.
        for (int i = 0; i < 13; i++) send(8'h63, 8'h00);
        check("col15_cursor", cursor_xy, 8'h0F);
        send(8'h5A, 8'h0F);
        check("colwrap_cursor", cursor_xy, 8'h10);
        idle(8'h0F);
        check("colwrap_read", rd_char, 8'h5A);

        // Control codes around 0x35.
        repeat (2) send(8'h0A, 8'h00);
        for (int i = 0; i < 5; i++) send(8'h2E, 8'h00);
        check("at_35", cursor_xy, 8'h35);
        send(8'h0D, 8'h00);
        check("cr_cursor", cursor_xy, 8'h30);
        send(8'h0A, 8'h00);
        check("lf_cursor", cursor_xy, 8'h40);
        send(8'h08, 8'h00);
        check("bs_col0_cursor", cursor_xy, 8'h40);
        send(8'h58, 8'h00);
        send(8'h08, 8'h40);
        check("bs_cursor", cursor_xy, 8'h40);
        idle(8'h40);
        check("bs_erased", rd_char, 8'h20);
        send(8'h01, 8'h40);
        check("unknown_cursor", cursor_xy, 8'h40);

        // Full-screen wrap from 0xFF to home.
        for (int i = 0; i < 11; i++) send(8'h0A, 8'h00);
        for (int i = 0; i < 15; i++) send(8'h2A, 8'h00);
        check("at_ff", cursor_xy, 8'hFF);
        send(8'h23, 8'h00);
        check("screen_wrap", cursor_xy, 8'h00);

        // clear_req with a byte offered in the same cycle.
        send(8'h31, 8'h00);
        cycle(8'h41, 1'b1, 1'b1, 8'h00, 1'b0);
        check("clrreq_cursor", cursor_xy, 8'h00);
        measure_sweep("clrreq_sweep_len");

        // FF mid-stream.
        send(8'h31, 8'h00);
        send(8'h32, 8'h00);
        send(8'h0C, 8'h00);
        check("ff_cursor", cursor_xy, 8'h00);
        measure_sweep("ff_sweep_len");

        // Reset pulse in the middle of a sweep restarts it.
        cycle(8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 99; i++) idle(8'($urandom));
        cycle(8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        measure_sweep("rst_mid_sweep_len");

        // Same-address read and write.
        send(8'h51, 8'h00);
        check("rbw_old", rd_char, 8'h20);
        idle(8'h00);
        check("rbw_new", rd_char, 8'h51);

        // Randomized stream.
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 70)      d = 8'($urandom_range(8'h20, 8'h7E));
            else if (sel < 78) d = 8'h0A;
            else if (sel < 84) d = 8'h0D;
            else if (sel < 93) d = 8'h08;
            else if (sel < 94) d = 8'h0C;
            else               d = 8'($urandom);
            a = 8'($urandom);
            cycle(d, $urandom_range(0, 3) != 0, $urandom_range(0, 599) == 0,
                  a, $urandom_range(0, 1499) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
